cook_timer_ctrl: RTL and testbench
==================================

COOK_TIMER_CTRL -- requirements
Module: cook_timer_ctrl

Interface
REQ-001 Parameter ALARM_TICKS, default 60: number of 1 Hz ticks the alarm state lasts before auto-clearing.
REQ-002 clk  input  1  system clock, 5 MHz domain; all logic runs on its rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low.
REQ-004 tick_1hz  input  1  single-cycle 1 Hz enable pulse, synchronous to clk.
REQ-005 enable  input  1  level; low freezes countdown.
REQ-006 cook_time  input  1  level; high selects time-configuration mode.
REQ-007 start_pulse  input  1  single-cycle pulse; start/pause toggle and alarm acknowledge.
REQ-008 mins_pulse  input  1  debounced single-cycle pulse; minutes increment.
REQ-009 secs_pulse  input  1  debounced single-cycle pulse; seconds increment.
REQ-010 min_bcd  output  8  displayed minutes, two BCD digits, 00..59.
REQ-011 sec_bcd  output  8  displayed seconds, two BCD digits, 00..59.
REQ-012 running  output  1  high in RUNNING.
REQ-013 LED_on  output  1  alarm indicator; toggles on each tick in ALARM.
REQ-014 LED_en  output  1  mirrors enable, registered.

Function
REQ-015 States: IDLE, CONFIG, PAUSED, RUNNING, ALARM; one registered state, next-state evaluated every clk.
REQ-016 cook_time high moves any state to CONFIG on the next clk; highest priority after reset.
REQ-017 CONFIG: mins_pulse increments min_bcd by 1, 59 wraps to 00; secs_pulse increments sec_bcd by 1, 59 wraps to 00, no carry into minutes.
REQ-018 mins_pulse and secs_pulse in the same cycle both apply; outside CONFIG both are ignored.
REQ-019 CONFIG exit (cook_time low): preset register := current MM:SS; go to PAUSED if nonzero, else IDLE.
REQ-020 IDLE: start_pulse ignored; display shows preset.
REQ-021 PAUSED: start_pulse with enable high and nonzero time goes to RUNNING next clk; with time 00:00 goes to IDLE.
REQ-022 RUNNING: each tick_1hz decrements MM:SS in BCD (SS 00 borrows: SS:=59, MM-1); one decrement per tick.
REQ-023 RUNNING: decrement reaching 00:00 enters ALARM in the same clk; LED_on set to 1.
REQ-024 RUNNING: start_pulse goes to PAUSED; start_pulse and tick_1hz in the same cycle: pause wins, no decrement.
REQ-025 enable low in RUNNING goes to PAUSED next clk; enable low blocks PAUSED to RUNNING.
REQ-026 ALARM: LED_on toggles on each tick; after ALARM_TICKS ticks, or on start_pulse, go to IDLE, LED_on := 0, MM:SS := preset.
REQ-027 LED_on is 0 in every state except ALARM.
REQ-028 Outputs registered; state-change and display latency exactly one clk from the triggering input.

Reset
REQ-029 rst low, asynchronously: state IDLE, min_bcd/sec_bcd/preset 00, alarm counter 0, running 0, LED_on 0, LED_en 0.
REQ-030 Reset mid-RUNNING or mid-ALARM discards the remaining time and the preset.
REQ-031 Release is synchronous; the first state change occurs on the second clk edge after rst goes high.

Structure
REQ-032 Shared package cook_timer_pkg holds the state enumeration, BCD_MAX_MIN/BCD_MAX_SEC = 59, and the default ALARM_TICKS.
REQ-033 One sub-module, bcd_mmss_counter: two-digit BCD MM:SS register with load, increment-minute, increment-second and decrement-with-borrow.
REQ-034 Alarm counter width is clog2(ALARM_TICKS+1).

Verification
REQ-035 CONFIG with 3 mins_pulse and 75 secs_pulse -> leave CONFIG -> min_bcd=03, sec_bcd=15, PAUSED.
REQ-036 Preset 01:00, start, 1 tick -> 00:59; 59 more ticks -> 00:00, ALARM, LED_on=1.
REQ-037 RUNNING at 00:10, start_pulse and tick_1hz in the same cycle -> PAUSED, display stays 00:10.
REQ-038 ALARM with ALARM_TICKS=4, 4 ticks -> LED_on sequence 1,0,1,0,1 then 0; IDLE, display = preset.
REQ-039 RUNNING at 00:30, enable low -> PAUSED next clk; start_pulse while enable low -> stays PAUSED.
REQ-040 RUNNING at 02:00, rst low between clocks -> outputs 00:00, IDLE, LED_on=0 immediately.

Source files
------------

// File: rtl/cook_timer_pkg.sv
// Shared types and constants for the cook timer: state encoding, BCD limits,
// default alarm duration and BCD digit-pair increment/decrement helpers.
package cook_timer_pkg;

  localparam int ALARM_TICKS_DEFAULT = 60;

  localparam logic [7:0] BCD_MAX_MIN = 8'h59;
  localparam logic [7:0] BCD_MAX_SEC = 8'h59;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_CONFIG  = 3'd1;
  localparam state_t ST_PAUSED  = 3'd2;
  localparam state_t ST_RUNNING = 3'd3;
  localparam state_t ST_ALARM   = 3'd4;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    if (v == 8'h00) return max;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// Two-digit BCD MM:SS register; load has priority over decrement, which has
// priority over the (independent) minute/second increments.
module bcd_mmss_counter
  import cook_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       inc_min,
  input  logic       inc_sec,
  input  logic       dec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_bcd <= 8'h00;
      sec_bcd <= 8'h00;
    end else if (load) begin
      min_bcd <= load_min;
      sec_bcd <= load_sec;
    end else if (dec) begin
      // Seconds at 00 borrow from minutes; caller never decrements 00:00.
      if (sec_bcd == 8'h00) begin
        sec_bcd <= BCD_MAX_SEC;
        min_bcd <= bcd_dec(min_bcd, BCD_MAX_MIN);
      end else begin
        sec_bcd <= bcd_dec(sec_bcd, BCD_MAX_SEC);
      end
    end else begin
      if (inc_min) min_bcd <= bcd_inc(min_bcd, BCD_MAX_MIN);
      if (inc_sec) sec_bcd <= bcd_inc(sec_bcd, BCD_MAX_SEC);
    end
  end

endmodule

// File: rtl/cook_timer_ctrl.sv
// Kitchen timer controller: configure MM:SS, run a 1 Hz BCD countdown, then
// blink the alarm LED until acknowledged or ALARM_TICKS ticks have elapsed.
module cook_timer_ctrl
  import cook_timer_pkg::*;
#(
  parameter int ALARM_TICKS = ALARM_TICKS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       enable,
  input  logic       cook_time,
  input  logic       start_pulse,
  input  logic       mins_pulse,
  input  logic       secs_pulse,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       LED_on,
  output logic       LED_en
);

  localparam int CW = $clog2(ALARM_TICKS + 1);
  localparam logic [CW-1:0] CNT_END = CW'(ALARM_TICKS);

  state_t        state, state_nxt;
  logic          armed;
  logic [7:0]    preset_min, preset_sec, preset_min_nxt, preset_sec_nxt;
  logic [CW-1:0] alarm_cnt, cnt_nxt;
  logic          led_nxt;
  logic          load, dec, inc_min, inc_sec;
  logic          time_zero, at_one;

  assign time_zero = (min_bcd == 8'h00) && (sec_bcd == 8'h00);
  assign at_one    = (min_bcd == 8'h00) && (sec_bcd == 8'h01);

  always_comb begin
    state_nxt      = state;
    preset_min_nxt = preset_min;
    preset_sec_nxt = preset_sec;
    cnt_nxt        = alarm_cnt;
    led_nxt        = LED_on;
    load           = 1'b0;
    dec            = 1'b0;
    inc_min        = 1'b0;
    inc_sec        = 1'b0;
    // First edge after reset release only arms the controller.
    if (armed) begin
      if (cook_time) begin
        state_nxt = ST_CONFIG;
        led_nxt   = 1'b0;
        if (state == ST_CONFIG) begin
          inc_min = mins_pulse;
          inc_sec = secs_pulse;
        end
      end else begin
        case (state)
          ST_CONFIG: begin
            preset_min_nxt = min_bcd;
            preset_sec_nxt = sec_bcd;
            state_nxt      = time_zero ? ST_IDLE : ST_PAUSED;
          end
          ST_PAUSED: begin
            if (start_pulse) begin
              if (time_zero)   state_nxt = ST_IDLE;
              else if (enable) state_nxt = ST_RUNNING;
            end
          end
          ST_RUNNING: begin
            if (start_pulse || !enable) begin
              state_nxt = ST_PAUSED;
            end else if (tick_1hz) begin
              dec = 1'b1;
              if (at_one) begin
                state_nxt = ST_ALARM;
                led_nxt   = 1'b1;
                cnt_nxt   = '0;
              end
            end
          end
          ST_ALARM: begin
            // The last toggle stays visible for one clock before the exit.
            if (start_pulse || alarm_cnt == CNT_END) begin
              state_nxt = ST_IDLE;
              led_nxt   = 1'b0;
              load      = 1'b1;
            end else if (tick_1hz) begin
              led_nxt = !LED_on;
              cnt_nxt = alarm_cnt + CW'(1);
            end
          end
          ST_IDLE: ;
          default: state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed      <= 1'b0;
      state      <= ST_IDLE;
      preset_min <= 8'h00;
      preset_sec <= 8'h00;
      alarm_cnt  <= '0;
      LED_on     <= 1'b0;
      running    <= 1'b0;
      LED_en     <= 1'b0;
    end else begin
      armed      <= 1'b1;
      state      <= state_nxt;
      preset_min <= preset_min_nxt;
      preset_sec <= preset_sec_nxt;
      alarm_cnt  <= cnt_nxt;
      LED_on     <= led_nxt;
      running    <= (state_nxt == ST_RUNNING);
      LED_en     <= enable;
    end
  end

  bcd_mmss_counter u_mmss (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_min (preset_min),
    .load_sec (preset_sec),
    .inc_min  (inc_min),
    .inc_sec  (inc_sec),
    .dec      (dec),
    .min_bcd  (min_bcd),
    .sec_bcd  (sec_bcd)
  );

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Directed bench for cook_timer_ctrl: expectations are queued with each stimulus
// step and checked against {min, sec, running, LED_on, LED_en} after the edge.
module tb_cook_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       enable = 1'b1;
  logic       cook_time = 1'b0;
  logic       start_pulse = 1'b0;
  logic       mins_pulse = 1'b0;
  logic       secs_pulse = 1'b0;
  logic [7:0] min_bcd, sec_bcd;
  logic       running, LED_on, LED_en;

  typedef struct {
    string       tag;
    logic [18:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  cook_timer_ctrl #(.ALARM_TICKS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_1hz    (tick_1hz),
    .enable      (enable),
    .cook_time   (cook_time),
    .start_pulse (start_pulse),
    .mins_pulse  (mins_pulse),
    .secs_pulse  (secs_pulse),
    .min_bcd     (min_bcd),
    .sec_bcd     (sec_bcd),
    .running     (running),
    .LED_on      (LED_on),
    .LED_en      (LED_en)
  );

  task automatic push(input string tag, input logic [7:0] m, input logic [7:0] s,
                      input logic r, input logic l, input logic e);
    exp_t x;
    x.tag = tag;
    x.val = {m, s, r, l, e};
    sb.push_back(x);
  endtask

  task automatic check();
    exp_t        x;
    logic [18:0] o;
    total++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty observed=none required=entry");
      return;
    end
    x = sb.pop_front();
    o = {min_bcd, sec_bcd, running, LED_on, LED_en};
    assert (o === x.val) passed++;
    else $error("FAIL %s observed mm:ss=%h:%h run=%b led=%b en=%b required mm:ss=%h:%h run=%b led=%b en=%b",
                x.tag, o[18:11], o[10:3], o[2], o[1], o[0],
                x.val[18:11], x.val[10:3], x.val[2], x.val[1], x.val[0]);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [7:0] m, input logic [7:0] s,
                      input logic r, input logic l, input logic e);
    push(tag, m, s, r, l, e);
    cyc();
    tick_1hz    = 1'b0;
    start_pulse = 1'b0;
    mins_pulse  = 1'b0;
    secs_pulse  = 1'b0;
    check();
  endtask

  task automatic cfg_pulses(input int nm, input int ns);
    for (int i = 0; i < nm; i++) begin
      mins_pulse = 1'b1;
      cyc();
    end
    mins_pulse = 1'b0;
    for (int i = 0; i < ns; i++) begin
      secs_pulse = 1'b1;
      cyc();
    end
    secs_pulse = 1'b0;
  endtask

  initial begin
    #2;
    push("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check();
    #20 rst = 1'b1;
    cyc();
    cyc();

    // Configure 3 minutes and 75 seconds (seconds wrap without carry).
    cook_time = 1'b1;
    step("cfg_enter", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      mins_pulse = 1'b1;
      secs_pulse = 1'b1;
      step($sformatf("cfg_both%0d", i), 8'(i), 8'(i), 1'b0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 71; i++) begin
      secs_pulse = 1'b1;
      cyc();
    end
    secs_pulse = 1'b1;
    step("cfg_75s", 8'h03, 8'h15, 1'b0, 1'b0, 1'b1);
    cook_time = 1'b0;
    step("cfg_exit", 8'h03, 8'h15, 1'b0, 1'b0, 1'b1);
    mins_pulse = 1'b1;
    secs_pulse = 1'b1;
    step("ign_outside_cfg", 8'h03, 8'h15, 1'b0, 1'b0, 1'b1);

    // 03:15 -> 01:00 through minute and second wrap.
    cook_time = 1'b1;
    step("cfg2_enter", 8'h03, 8'h15, 1'b0, 1'b0, 1'b1);
    cfg_pulses(58, 45);
    step("cfg2_wrap", 8'h01, 8'h00, 1'b0, 1'b0, 1'b1);
    cook_time = 1'b0;
    step("cfg2_exit", 8'h01, 8'h00, 1'b0, 1'b0, 1'b1);

    start_pulse = 1'b1;
    step("start", 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    tick_1hz = 1'b1;
    step("tick_borrow", 8'h00, 8'h59, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 58; i++) begin
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
      cyc();
    end
    step("at_0001", 8'h00, 8'h01, 1'b1, 1'b0, 1'b1);
    tick_1hz = 1'b1;
    step("alarm_enter", 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);

    for (int i = 1; i <= 4; i++) begin
      tick_1hz = 1'b1;
      step($sformatf("alarm_led%0d", i), 8'h00, 8'h00, 1'b0, (i % 2 == 0), 1'b1);
      if (i < 4) step($sformatf("alarm_hold%0d", i), 8'h00, 8'h00, 1'b0, (i % 2 == 0), 1'b1);
    end
    step("alarm_done", 8'h01, 8'h00, 1'b0, 1'b0, 1'b1);
    start_pulse = 1'b1;
    step("idle_start", 8'h01, 8'h00, 1'b0, 1'b0, 1'b1);

    // Pause beats a simultaneous tick.
    cook_time = 1'b1;
    step("cfg3_enter", 8'h01, 8'h00, 1'b0, 1'b0, 1'b1);
    cfg_pulses(59, 10);
    cook_time = 1'b0;
    step("cfg3_exit", 8'h00, 8'h10, 1'b0, 1'b0, 1'b1);
    start_pulse = 1'b1;
    step("run3", 8'h00, 8'h10, 1'b1, 1'b0, 1'b1);
    start_pulse = 1'b1;
    tick_1hz = 1'b1;
    step("pause_wins", 8'h00, 8'h10, 1'b0, 1'b0, 1'b1);
    tick_1hz = 1'b1;
    step("paused_tick", 8'h00, 8'h10, 1'b0, 1'b0, 1'b1);

    // Enable low pauses and blocks resume.
    cook_time = 1'b1;
    step("cfg4_enter", 8'h00, 8'h10, 1'b0, 1'b0, 1'b1);
    cfg_pulses(0, 20);
    cook_time = 1'b0;
    step("cfg4_exit", 8'h00, 8'h30, 1'b0, 1'b0, 1'b1);
    start_pulse = 1'b1;
    step("run4", 8'h00, 8'h30, 1'b1, 1'b0, 1'b1);
    enable = 1'b0;
    step("enable_low", 8'h00, 8'h30, 1'b0, 1'b0, 1'b0);
    start_pulse = 1'b1;
    step("start_en_low", 8'h00, 8'h30, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    start_pulse = 1'b1;
    step("resume", 8'h00, 8'h30, 1'b1, 1'b0, 1'b1);

    // Leaving CONFIG at 00:00 lands in IDLE.
    cook_time = 1'b1;
    step("cfg5_from_run", 8'h00, 8'h30, 1'b0, 1'b0, 1'b1);
    cfg_pulses(0, 30);
    cook_time = 1'b0;
    step("cfg5_exit_zero", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    start_pulse = 1'b1;
    step("idle_zero_start", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in RUNNING at 02:00.
    cook_time = 1'b1;
    step("cfg6_enter", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    cfg_pulses(2, 0);
    cook_time = 1'b0;
    step("cfg6_exit", 8'h02, 8'h00, 1'b0, 1'b0, 1'b1);
    start_pulse = 1'b1;
    step("run6", 8'h02, 8'h00, 1'b1, 1'b0, 1'b1);
    #3 rst = 1'b0;
    #1;
    push("async_reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check();
    #2 rst = 1'b1;
    cyc();
    cyc();
    start_pulse = 1'b1;
    step("post_reset_start", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
